mac_seq_acc: RTL and testbench
==============================

# mac_seq_acc

Parametrised sequential multiply-accumulate engine: one multiplier step per clock, with signed/unsigned mode, a running accumulator, overflow detection, and an optional saturating accumulate. It drops in where the single-shot MAC sits today and keeps the same start/ready handshake so existing drivers still apply. Intended users are filter and dot-product datapaths that issue back-to-back operand pairs into one accumulator.

## Interface
- DATA_WIDTH, 8, operand width in bits (≥2)
- ACC_WIDTH, 20, accumulator/result width in bits (must be ≥ 2*DATA_WIDTH; elaboration error otherwise)

- clk  input  1  single clock, rising-edge
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- m_in  input  DATA_WIDTH  multiplicand, latched on accepted start
- q_in  input  DATA_WIDTH  multiplier, latched on accepted start
- signed_mode  input  1  1 = two's-complement operands and accumulator; latched with start
- acc_en  input  1  1 = add product to accumulator; 0 = overwrite; latched with start
- clear  input  1  zero accumulator and overflow flag; honoured only in IDLE
- product  output  ACC_WIDTH  accumulator value
- ready  output  1  result valid; sticky until next accepted start
- busy  output  1  high in CALC and ACC
- overflow  output  1  sticky accumulate overflow

## Operation
- FSM states: IDLE, CALC, ACC.
- IDLE + start=1: latch operands and mode bits, clear step counter, ready←0, go to CALC. start in any other state is ignored and not queued.
- CALC: one radix-2 step per cycle, producing a 2*DATA_WIDTH partial product. Unsigned: shift-add. Signed: Booth radix-2. After DATA_WIDTH steps, go to ACC.
- ACC: extend the product to ACC_WIDTH (sign-extend if signed_mode, else zero-extend). Then product ← (acc_en ? product + ext : ext). Set ready←1 and go to IDLE.
- Overflow on the ACC add:
  - Unsigned: carry out of ACC_WIDTH.
  - Signed: operands have the same sign and the result sign differs.
  - When acc_en=0, overflow is not evaluated and the flag is unchanged.
  - overflow is sticky and is cleared by clear or reset.
- clear in IDLE: product←0 and overflow←0 at the next edge, ready unchanged.
- clear and start in the same IDLE cycle: clear takes effect, the operation starts, and it accumulates onto 0.
- clear outside IDLE is ignored.
- Inputs m_in, q_in, signed_mode and acc_en may change freely after acceptance.

## Timing
- Reset values: product=0, ready=0, busy=0, overflow=0, state=IDLE. Reset takes effect immediately and asynchronously, including mid-CALC/ACC; the partial result is discarded.
- Latency: start accepted at edge k. busy is high from after edge k until edge k+DATA_WIDTH+1. ready and the new product are visible after edge k+DATA_WIDTH+1, i.e. DATA_WIDTH+1 cycles after acceptance.
- Throughput: a new start may be accepted in the first IDLE cycle after ready rises. Back-to-back period is DATA_WIDTH+2 cycles.
- ready stays high while IDLE and falls on the edge that accepts the next start.
- product is stable outside the ACC edge and changes only at ACC, clear, or reset.

## Configuration
- MAC_SATURATE_EN defined: on overflow, the accumulator clamps instead of wrapping; overflow is still set.
  - Unsigned clamp: all-ones.
  - Signed clamp: 2^(ACC_WIDTH-1)-1 on positive overflow, -2^(ACC_WIDTH-1) on negative overflow.
- MAC_SATURATE_EN undefined: modulo-2^ACC_WIDTH wrap; overflow flag only.

## Test plan
With DATA_WIDTH=8, ACC_WIDTH=20:
- Unsigned overwrite: start with m=200, q=100, acc_en=0 → ready exactly 9 edges after acceptance, product=0x04E20, busy high for those 9 cycles.
- Signed overwrite: m=0xFD (−3), q=0x05, signed_mode=1 → product=0xFFFF1. Then m=0x80, q=0x80 → product=0x04000.
- Accumulate chain: clear, then 3×7, 4×5 and 2×(−6) signed with acc_en=1 → product=21, 41, 29 in turn. A start pulsed during busy is ignored and the chain result is unchanged.
- Overflow: clear, then 17 unsigned accumulates of 255×255.
  - Wrap build: product=0x0DE11 (56849) with overflow=1.
  - MAC_SATURATE_EN build: product=0xFFFFF with overflow=1.
  - A following clear zeroes both.
- Reset mid-operation: drop rst_n 3 cycles into CALC → product, ready, busy and overflow are 0 immediately. After release, a fresh 12×12 gives 144 with standard latency.
- Simultaneous clear+start with acc_en=1 on a nonzero accumulator, m=10, q=10 → product=100.

Source files
------------

// File: rtl/mac_seq_acc.sv
// mac_seq_acc: sequential multiply-accumulate engine.
// Takes one radix-2 multiplier step per clock: shift-add for unsigned
// operands, Booth radix-2 for signed. The product then goes into (or
// overwrites) a running accumulator, and accumulate overflow is detected.
// Optional feature: define MAC_SATURATE_EN to clamp the accumulator on
// overflow instead of letting it wrap modulo 2^ACC_WIDTH.
module mac_seq_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] m_in,
  input  logic [DATA_WIDTH-1:0] q_in,
  input  logic                  signed_mode,
  input  logic                  acc_en,
  input  logic                  clear,
  output logic [ACC_WIDTH-1:0]  product,
  output logic                  ready,
  output logic                  busy,
  output logic                  overflow
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;

  if (DATA_WIDTH < 2) begin : g_dw_check
    $error("mac_seq_acc: DATA_WIDTH must be >= 2");
  end
  if (ACC_WIDTH < PW) begin : g_aw_check
    $error("mac_seq_acc: ACC_WIDTH must be >= 2*DATA_WIDTH");
  end

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] m_reg;
  logic [DATA_WIDTH:0]   a_reg;     // one guard bit so A +/- M cannot overflow
  logic [DATA_WIDTH-1:0] q_reg;
  logic                  qm1;       // Booth q[-1] bit
  logic                  sm_reg;
  logic                  ae_reg;
  logic [CW-1:0]         step_cnt;

  logic [DATA_WIDTH:0]   m_ext;
  logic [DATA_WIDTH:0]   a_sum;
  logic                  shift_in;
  logic [DATA_WIDTH:0]   a_nxt;
  logic [DATA_WIDTH-1:0] q_nxt;
  logic                  qm1_nxt;
  logic [PW-1:0]         mult_res;
  logic [ACC_WIDTH-1:0]  ext;
  logic [ACC_WIDTH:0]    sum;
  logic                  ovf_u;
  logic                  ovf_s;
  logic                  ovf;
  logic [ACC_WIDTH-1:0]  acc_val;
  logic                  last_step;

  assign busy      = (state == CALC) || (state == ACC);
  assign last_step = (step_cnt == CW'(DATA_WIDTH - 1));

  // One multiplier step: conditional add/subtract followed by a right shift of {A,Q,q-1}
  always_comb begin
    m_ext    = sm_reg ? {m_reg[DATA_WIDTH-1], m_reg} : {1'b0, m_reg};
    a_sum    = a_reg;
    if (sm_reg) begin
      case ({q_reg[0], qm1})
        2'b01:   a_sum = a_reg + m_ext;
        2'b10:   a_sum = a_reg - m_ext;
        default: a_sum = a_reg;
      endcase
    end else if (q_reg[0]) begin
      a_sum = a_reg + m_ext;
    end
    // Unsigned partial sums never set the guard bit after a shift, so a zero fill is exact
    shift_in = sm_reg ? a_sum[DATA_WIDTH] : 1'b0;
    {a_nxt, q_nxt, qm1_nxt} = {shift_in, a_sum, q_reg};
  end

  // Extend the finished product, form the accumulate sum and detect overflow
  always_comb begin
    mult_res = {a_reg[DATA_WIDTH-1:0], q_reg};
    ext      = sm_reg ? ACC_WIDTH'(signed'(mult_res)) : ACC_WIDTH'(mult_res);
    sum      = {1'b0, product} + {1'b0, ext};
    ovf_u    = sum[ACC_WIDTH];
    ovf_s    = (product[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
               (sum[ACC_WIDTH-1] != product[ACC_WIDTH-1]);
    ovf      = ae_reg && (sm_reg ? ovf_s : ovf_u);
    acc_val  = ext;
    if (ae_reg) begin
`ifdef MAC_SATURATE_EN
      if (ovf) begin
        if (!sm_reg)
          acc_val = '1;
        else if (product[ACC_WIDTH-1])
          acc_val = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
          acc_val = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        acc_val = sum[ACC_WIDTH-1:0];
      end
`else
      acc_val = sum[ACC_WIDTH-1:0];
`endif
    end
  end

  // Control FSM plus accumulator, ready and overflow state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      product  <= '0;
      ready    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A same-cycle clear zeroes the accumulator before the new op lands on it
          if (clear) begin
            product  <= '0;
            overflow <= 1'b0;
          end
          if (start) begin
            ready <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          if (last_step)
            state <= ACC;
        end
        ACC: begin
          product <= acc_val;
          if (ovf)
            overflow <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand latch on accept and per-cycle multiplier datapath update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg    <= '0;
      a_reg    <= '0;
      q_reg    <= '0;
      qm1      <= 1'b0;
      sm_reg   <= 1'b0;
      ae_reg   <= 1'b0;
      step_cnt <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        m_reg    <= m_in;
        q_reg    <= q_in;
        a_reg    <= '0;
        qm1      <= 1'b0;
        sm_reg   <= signed_mode;
        ae_reg   <= acc_en;
        step_cnt <= '0;
      end
    end else if (state == CALC) begin
      a_reg    <= a_nxt;
      q_reg    <= q_nxt;
      qm1      <= qm1_nxt;
      step_cnt <= step_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_seq_acc.sv
// tb_mac_seq_acc: directed-vector bench for mac_seq_acc (DATA_WIDTH=8, ACC_WIDTH=20).
module tb_mac_seq_acc;

  localparam int DW = 8;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] m_in = '0;
  logic [DW-1:0] q_in = '0;
  logic          signed_mode = 1'b0;
  logic          acc_en = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] product;
  logic          ready;
  logic          busy;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  mac_seq_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m_in(m_in), .q_in(q_in),
    .signed_mode(signed_mode), .acc_en(acc_en), .clear(clear),
    .product(product), .ready(ready), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for ready. Returns edges from accept to ready
  // and whether busy was continuously high until then. If poke is set, a stray start
  // with junk operands is pulsed mid-CALC; it must be ignored.
  task automatic run_op(input logic [DW-1:0] m, input logic [DW-1:0] q, input logic sm,
                        input logic ae, input logic cl, input logic poke,
                        output int lat, output logic busy_ok);
    @(negedge clk);
    m_in = m; q_in = q; signed_mode = sm; acc_en = ae; clear = cl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    m_in = 8'hA5; q_in = 8'h3C; signed_mode = ~sm; acc_en = ~ae;
    lat = 0;
    busy_ok = 1'b1;
    while (!ready && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (poke && lat == 3) begin
        @(negedge clk);
        start = 1'b1; m_in = 8'h63; q_in = 8'h63;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      lat++;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  int   lat;
  logic bok;
  logic rdy_before;

  initial begin
    // Reset state
    #2;
    check("rst_product", 32'(product), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned overwrite 200*100
    run_op(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, lat, bok);
    check("u_latency", 32'(lat), 32'd9);
    check("u_busy_during", 32'(bok), 32'h1);
    check("u_busy_after", 32'(busy), 32'h0);
    check("u_product", 32'(product), 32'h04E20);
    repeat (3) @(negedge clk);
    check("u_ready_sticky", 32'(ready), 32'h1);

    // Signed overwrite
    run_op(8'hFD, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, lat, bok);
    check("s_neg3x5", 32'(product), 32'hFFFF1);
    run_op(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, lat, bok);
    check("s_min_x_min", 32'(product), 32'h04000);

    // Signed accumulate chain; clear keeps ready as it was
    @(negedge clk);
    rdy_before = ready;
    do_clear();
    check("clr_product", 32'(product), 32'h0);
    check("clr_ready_kept", 32'(ready), 32'(rdy_before));
    run_op(8'd3, 8'd7, 1'b1, 1'b1, 1'b0, 1'b0, lat, bok);
    check("chain_21", 32'(product), 32'd21);
    run_op(8'd4, 8'd5, 1'b1, 1'b1, 1'b0, 1'b1, lat, bok);
    check("chain_41_poke", 32'(product), 32'd41);
    check("chain_poke_latency", 32'(lat), 32'd9);
    repeat (3) @(negedge clk);
    check("poke_not_queued", 32'(busy), 32'h0);
    run_op(8'd2, 8'hFA, 1'b1, 1'b1, 1'b0, 1'b0, lat, bok);
    check("chain_29", 32'(product), 32'd29);

    // Unsigned overflow after 17 accumulates of 255*255
    do_clear();
    for (int i = 0; i < 17; i++) begin
      run_op(8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0, lat, bok);
      if (i == 15) check("ovf_not_yet", 32'(overflow), 32'h0);
    end
`ifdef MAC_SATURATE_EN
    check("ovf_product_sat", 32'(product), 32'hFFFFF);
`else
    check("ovf_product_wrap", 32'(product), 32'h0DE11);
`endif
    check("ovf_flag", 32'(overflow), 32'h1);
    run_op(8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, lat, bok);
    check("ovf_overwrite_prod", 32'(product), 32'h1);
    check("ovf_sticky", 32'(overflow), 32'h1);
    do_clear();
    check("ovf_clr_product", 32'(product), 32'h0);
    check("ovf_clr_flag", 32'(overflow), 32'h0);

    // Asynchronous reset in the middle of CALC
    run_op(8'd9, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, lat, bok);
    @(negedge clk);
    m_in = 8'd50; q_in = 8'd50; signed_mode = 1'b0; acc_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_product", 32'(product), 32'h0);
    check("mid_rst_ready", 32'(ready), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd12, 8'd12, 1'b0, 1'b0, 1'b0, 1'b0, lat, bok);
    check("post_rst_144", 32'(product), 32'd144);
    check("post_rst_latency", 32'(lat), 32'd9);

    // Clear and start together accumulate onto zero
    run_op(8'd10, 8'd10, 1'b0, 1'b1, 1'b1, 1'b0, lat, bok);
    check("clr_start_100", 32'(product), 32'd100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
